// File: rtl/mac_seq_pkg.sv
// Shared types for the MAC operand sequencer: FSM states, FIFO beat format
// and the read-credit rule used to keep the beat FIFO from overflowing.
package mac_seq_pkg;

   localparam int FIFO_DEPTH  = 2;
   localparam int CNT_W       = 2;
   // Sized for the widest supported operand pair (2 x 32 bits).
   localparam int BEAT_DATA_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BIAS   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [BEAT_DATA_W-1:0] data;
      logic                   user;
      logic                   last;
   } beat_t;

   // Occupancy after this cycle's pop plus the beat still in flight must leave room
   // for one more, which lets a read issue in the same cycle a beat leaves.
   function automatic logic credit_ok(input logic [CNT_W-1:0] count,
                                      input logic             pop,
                                      input logic             inflight);
      logic [CNT_W:0] used;
      used = {1'b0, count} - {{CNT_W{1'b0}}, pop} + {{CNT_W{1'b0}}, inflight};
      return used < (CNT_W+1)'(FIFO_DEPTH);
   endfunction

endpackage

// File: rtl/mac_seq_skid_fifo.sv
// Two-entry beat FIFO whose head entry drives the M_AXIS outputs directly;
// exposes its occupancy so the sequencer can meter BRAM reads.
module mac_seq_skid_fifo
   import mac_seq_pkg::*;
(
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             push,
   input  beat_t            push_beat,
   input  logic             out_ready,
   output logic             out_valid,
   output beat_t            out_beat,
   output logic [CNT_W-1:0] count
);

   beat_t            mem [FIFO_DEPTH];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             pop;

   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign out_beat  = mem[rd_ptr];
   assign count     = count_q;

   // A push while full is only ever paired with a pop, so the slot written is the one leaving.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Reads paired weight/activation operands from two BRAM ports and streams them as AXIS beats.
// Optional leading bias beat is built only when MAC_SEQ_BIAS_EN is defined.
module mac_operand_sequencer
   import mac_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 16
)
(
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   input  logic [ADDR_WIDTH-1:0]   CMD_W_BASE,
   input  logic [ADDR_WIDTH-1:0]   CMD_A_BASE,
   input  logic [LEN_WIDTH-1:0]    CMD_LEN,
   input  logic [7:0]              CMD_TID,
`ifdef MAC_SEQ_BIAS_EN
   input  logic [DATA_WIDTH-1:0]   CMD_BIAS,
   input  logic                    CMD_BIAS_VLD,
`endif
   output logic                    W_RD_EN,
   output logic [ADDR_WIDTH-1:0]   W_RD_ADDR,
   input  logic [DATA_WIDTH-1:0]   W_RD_DATA,
   output logic                    A_RD_EN,
   output logic [ADDR_WIDTH-1:0]   A_RD_ADDR,
   input  logic [DATA_WIDTH-1:0]   A_RD_DATA,
   output logic                    M_AXIS_TVALID,
   input  logic                    M_AXIS_TREADY,
   output logic [2*DATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                    M_AXIS_TUSER,
   output logic                    M_AXIS_TLAST,
   output logic [7:0]              M_AXIS_TID,
   output logic                    BUSY,
   output logic                    CMD_ERR,
   output seq_state_t              DBG_STATE
);

   // Handshakes: a transfer happens on a rising edge where VALID && READY; VALID never
   // waits on READY, and the payload holds while VALID is high and READY is low.

   seq_state_t             state_q;
   seq_state_t             state_d;
   logic [ADDR_WIDTH-1:0]  w_addr_q;
   logic [ADDR_WIDTH-1:0]  a_addr_q;
   logic [LEN_WIDTH-1:0]   remain_q;
   logic [7:0]             tid_q;
   logic                   err_q;
   logic                   rsp_vld_q;
   logic                   rsp_last_q;

   logic                   cmd_ready;
   logic                   accept;
   logic                   want_bias;
   logic                   issue_rd;
   logic                   issue_bias;
   logic                   can_issue;
   logic                   pop;
   logic                   push_user;
   logic [2*DATA_WIDTH-1:0] push_pair;
   beat_t                  push_beat;
   beat_t                  head_beat;
   logic                   fifo_valid;
   logic [CNT_W-1:0]       fifo_count;

   assign cmd_ready = (state_q == ST_IDLE) && !ARESET;
   assign accept    = CMD_VALID && cmd_ready;
   assign pop       = fifo_valid && M_AXIS_TREADY;
   assign can_issue = credit_ok(fifo_count, pop, rsp_vld_q);

   always_comb begin
      state_d    = state_q;
      issue_rd   = 1'b0;
      issue_bias = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && (CMD_LEN != '0)) begin
               state_d = want_bias ? ST_BIAS : ST_STREAM;
            end
         end
`ifdef MAC_SEQ_BIAS_EN
         ST_BIAS: begin
            if (can_issue && !ARESET) begin
               issue_bias = 1'b1;
               state_d    = ST_STREAM;
            end
         end
`endif
         ST_STREAM: begin
            if (can_issue && !ARESET) begin
               issue_rd = 1'b1;
               if (remain_q == LEN_WIDTH'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && head_beat.last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= ST_IDLE;
         w_addr_q   <= '0;
         a_addr_q   <= '0;
         remain_q   <= '0;
         tid_q      <= '0;
         err_q      <= 1'b0;
         rsp_vld_q  <= 1'b0;
         rsp_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= accept && (CMD_LEN == '0);
         rsp_vld_q  <= issue_rd || issue_bias;
         rsp_last_q <= issue_rd && (remain_q == LEN_WIDTH'(1));
         if (accept) begin
            w_addr_q <= CMD_W_BASE;
            a_addr_q <= CMD_A_BASE;
            remain_q <= CMD_LEN;
            tid_q    <= CMD_TID;
         end else if (issue_rd) begin
            w_addr_q <= w_addr_q + ADDR_WIDTH'(1);
            a_addr_q <= a_addr_q + ADDR_WIDTH'(1);
            remain_q <= remain_q - LEN_WIDTH'(1);
         end
      end
   end

`ifdef MAC_SEQ_BIAS_EN
   logic [DATA_WIDTH-1:0] bias_q;
   logic                  rsp_bias_q;

   // The bias beat rides the same one-cycle return slot as BRAM data, so both beat
   // kinds share one push path and one credit rule.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         bias_q     <= '0;
         rsp_bias_q <= 1'b0;
      end else begin
         rsp_bias_q <= issue_bias;
         if (accept) begin
            bias_q <= CMD_BIAS;
         end
      end
   end

   assign want_bias = CMD_BIAS_VLD;
   assign push_user = rsp_bias_q;
   assign push_pair = rsp_bias_q ? {{DATA_WIDTH{1'b0}}, bias_q} : {W_RD_DATA, A_RD_DATA};
`else
   assign want_bias = 1'b0;
   assign push_user = 1'b0;
   assign push_pair = {W_RD_DATA, A_RD_DATA};
`endif

   always_comb begin
      push_beat                         = '0;
      push_beat.data[2*DATA_WIDTH-1:0]  = push_pair;
      push_beat.user                    = push_user;
      push_beat.last                    = rsp_last_q;
   end

   mac_seq_skid_fifo u_fifo (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .push      (rsp_vld_q),
      .push_beat (push_beat),
      .out_ready (M_AXIS_TREADY),
      .out_valid (fifo_valid),
      .out_beat  (head_beat),
      .count     (fifo_count)
   );

   assign CMD_READY     = cmd_ready;
   assign W_RD_EN       = issue_rd;
   assign A_RD_EN       = issue_rd;
   assign W_RD_ADDR     = w_addr_q;
   assign A_RD_ADDR     = a_addr_q;
   assign M_AXIS_TVALID = fifo_valid;
   assign M_AXIS_TDATA  = head_beat.data[2*DATA_WIDTH-1:0];
   assign M_AXIS_TUSER  = head_beat.user;
   assign M_AXIS_TLAST  = head_beat.last;
   assign M_AXIS_TID    = tid_q;
   assign BUSY          = (state_q != ST_IDLE) || fifo_valid || rsp_vld_q;
   assign CMD_ERR       = err_q;
   assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench for mac_operand_sequencer: BRAM model, beat/address scoreboards,
// directed latency, wrap, zero-length and reset cases; bias cases under MAC_SEQ_BIAS_EN.
`timescale 1ns/1ps
module tb_mac_operand_sequencer;
   import mac_seq_pkg::*;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int LW = 16;
   localparam int PW = 2*DW + 2 + 8;

   logic            ACLK = 1'b0;
   logic            ARESET = 1'b1;
   logic            CMD_VALID;
   logic            CMD_READY;
   logic [AW-1:0]   CMD_W_BASE;
   logic [AW-1:0]   CMD_A_BASE;
   logic [LW-1:0]   CMD_LEN;
   logic [7:0]      CMD_TID;
`ifdef MAC_SEQ_BIAS_EN
   logic [DW-1:0]   CMD_BIAS;
   logic            CMD_BIAS_VLD;
`endif
   logic            W_RD_EN;
   logic [AW-1:0]   W_RD_ADDR;
   logic [DW-1:0]   W_RD_DATA;
   logic            A_RD_EN;
   logic [AW-1:0]   A_RD_ADDR;
   logic [DW-1:0]   A_RD_DATA;
   logic            M_AXIS_TVALID;
   logic            M_AXIS_TREADY;
   logic [2*DW-1:0] M_AXIS_TDATA;
   logic            M_AXIS_TUSER;
   logic            M_AXIS_TLAST;
   logic [7:0]      M_AXIS_TID;
   logic            BUSY;
   logic            CMD_ERR;
   seq_state_t      DBG_STATE;

   mac_operand_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .CMD_VALID     (CMD_VALID),
      .CMD_READY     (CMD_READY),
      .CMD_W_BASE    (CMD_W_BASE),
      .CMD_A_BASE    (CMD_A_BASE),
      .CMD_LEN       (CMD_LEN),
      .CMD_TID       (CMD_TID),
`ifdef MAC_SEQ_BIAS_EN
      .CMD_BIAS      (CMD_BIAS),
      .CMD_BIAS_VLD  (CMD_BIAS_VLD),
`endif
      .W_RD_EN       (W_RD_EN),
      .W_RD_ADDR     (W_RD_ADDR),
      .W_RD_DATA     (W_RD_DATA),
      .A_RD_EN       (A_RD_EN),
      .A_RD_ADDR     (A_RD_ADDR),
      .A_RD_DATA     (A_RD_DATA),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TUSER  (M_AXIS_TUSER),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .M_AXIS_TID    (M_AXIS_TID),
      .BUSY          (BUSY),
      .CMD_ERR       (CMD_ERR),
      .DBG_STATE     (DBG_STATE)
   );

   // ---------------- clock / reset ----------------
   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   // ---------------- BRAM model (1-cycle read latency) ----------------
   logic [DW-1:0] w_mem [1<<AW];
   logic [DW-1:0] a_mem [1<<AW];

   always @(posedge ACLK) begin
      if (W_RD_EN) W_RD_DATA <= w_mem[W_RD_ADDR];
      if (A_RD_EN) A_RD_DATA <= a_mem[A_RD_ADDR];
   end

   // ---------------- scoreboard state ----------------
   logic [PW-1:0]   exp_q[$];
   logic [2*AW-1:0] addr_q[$];
   logic [AW-1:0]   rd_log[$];
   int              beat_cyc[$];
   int              n_chk = 0;
   int              n_pass = 0;
   int              n_rd = 0;
   int              n_pop = 0;
   logic            prev_stall = 1'b0;
   logic [PW-1:0]   prev_pay;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- ready driver ----------------
   int rdy_mode = 0;
   int rdy_ph = 0;

   initial begin
      M_AXIS_TREADY = 1'b0;
      forever begin
         @(posedge ACLK);
         #1;
         rdy_ph++;
         case (rdy_mode)
            0:       M_AXIS_TREADY = 1'b1;
            1:       M_AXIS_TREADY = rdy_ph[0];
            2:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
            3:       M_AXIS_TREADY = ((rdy_ph % 5) >= 3);
            default: M_AXIS_TREADY = 1'b0;
         endcase
      end
   end

   // ---------------- monitor ----------------
   always @(negedge ACLK) begin
      logic [PW-1:0]   pay;
      logic [2*AW-1:0] ea;
      pay = {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TID};
      if (ARESET) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("hold", {M_AXIS_TVALID, pay}, {1'b1, prev_pay});
         if (W_RD_EN || A_RD_EN) chk("a_rd_en", A_RD_EN, W_RD_EN);
         if (W_RD_EN) begin
            chk("outstanding", (n_rd - n_pop) <= 2, 1'b1);
            if (addr_q.size() == 0) begin
               chk("rd_unexpected", {W_RD_ADDR, A_RD_ADDR}, 0);
            end else begin
               ea = addr_q.pop_front();
               chk("rd_addr", {W_RD_ADDR, A_RD_ADDR}, ea);
            end
            rd_log.push_back(W_RD_ADDR);
            n_rd++;
         end
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (exp_q.size() == 0) chk("beat_unexpected", pay, 0);
            else chk("beat", pay, exp_q.pop_front());
            beat_cyc.push_back(cyc);
            n_pop++;
         end
         prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
         prev_pay   = pay;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [AW-1:0] wb, input logic [AW-1:0] ab, input logic [LW-1:0] len,
                       input logic [7:0] tid, input logic bias_en, input logic [DW-1:0] bias,
                       output int acc);
      int            t;
      logic [AW-1:0] wa;
      logic [AW-1:0] aa;
      t = 0;
      @(negedge ACLK);
      while (!CMD_READY && t < 200) begin
         @(negedge ACLK);
         t++;
      end
      chk("cmd_ready_wait", CMD_READY, 1'b1);
      CMD_VALID  = 1'b1;
      CMD_W_BASE = wb;
      CMD_A_BASE = ab;
      CMD_LEN    = len;
      CMD_TID    = tid;
`ifdef MAC_SEQ_BIAS_EN
      CMD_BIAS     = bias;
      CMD_BIAS_VLD = bias_en;
`endif
      if (len != 0) begin
         if (bias_en) exp_q.push_back({{DW{1'b0}}, bias, 1'b1, 1'b0, tid});
         for (int i = 0; i < int'(len); i++) begin
            wa = wb + AW'(i);
            aa = ab + AW'(i);
            exp_q.push_back({w_mem[wa], a_mem[aa], 1'b0, (i == int'(len) - 1), tid});
            addr_q.push_back({wa, aa});
         end
      end
      @(posedge ACLK);
      #1;
      acc       = cyc;
      CMD_VALID = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      do begin
         @(negedge ACLK);
         t++;
      end while ((BUSY || exp_q.size() != 0) && t < 3000);
      chk(tag, {BUSY, exp_q.size() == 0, CMD_READY}, 3'b011);
   endtask

   task automatic do_reset();
      @(posedge ACLK);
      #1;
      ARESET = 1'b1;
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      exp_q.delete();
      addr_q.delete();
      n_rd  = 0;
      n_pop = 0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      n_chk++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // ---------------- main sequence ----------------
   logic [AW-1:0] wrap_exp [4];
   int            acc;

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         w_mem[i] = $urandom;
         a_mem[i] = $urandom;
      end
      CMD_VALID  = 1'b0;
      CMD_W_BASE = '0;
      CMD_A_BASE = '0;
      CMD_LEN    = '0;
      CMD_TID    = '0;
`ifdef MAC_SEQ_BIAS_EN
      CMD_BIAS     = '0;
      CMD_BIAS_VLD = 1'b0;
`endif
      W_RD_DATA = '0;
      A_RD_DATA = '0;
      repeat (3) @(posedge ACLK);
      #1;
      ARESET = 1'b0;

      // reset state
      @(negedge ACLK);
      chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
      chk("rst_cmd_ready", CMD_READY, 1'b1);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_cmd_err", CMD_ERR, 1'b0);
      chk("rst_rd_en", {W_RD_EN, A_RD_EN}, 2'b00);
      chk("rst_payload", {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TID}, 0);

      // LEN=4, bases 0x10/0x20, back-to-back beats two cycles after accept
      rdy_mode = 0;
      beat_cyc.delete();
      send(10'h010, 10'h020, 16'd4, 8'h5A, 1'b0, '0, acc);
      wait_idle("len4_idle");
      chk("len4_nbeats", beat_cyc.size(), 4);
      for (int i = 0; i < beat_cyc.size() && i < 4; i++) chk("len4_beat_cycle", beat_cyc[i], acc + 2 + i);

      // address wrap
      wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      rd_log.delete();
      send(10'h3FE, AW'($urandom), 16'd4, 8'h33, 1'b0, '0, acc);
      wait_idle("wrap_idle");
      chk("wrap_nreads", rd_log.size(), 4);
      for (int i = 0; i < rd_log.size() && i < 4; i++) chk("wrap_addr", rd_log[i], wrap_exp[i]);

      // zero-length command
      send(10'h100, 10'h200, 16'd0, 8'h77, 1'b0, '0, acc);
      @(negedge ACLK);
      chk("len0_err_pulse", CMD_ERR, 1'b1);
      chk("len0_ready", CMD_READY, 1'b1);
      chk("len0_tvalid", M_AXIS_TVALID, 1'b0);
      @(negedge ACLK);
      chk("len0_err_clear", CMD_ERR, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("len0_quiet", {M_AXIS_TVALID, W_RD_EN, BUSY}, 3'b000);
         @(negedge ACLK);
      end

      // LEN=8 under toggling ready, then under 3-cycle stalls
      rdy_mode = 1;
      send(10'h040, 10'h0C0, 16'd8, 8'h81, 1'b0, '0, acc);
      wait_idle("toggle_idle");
      rdy_mode = 3;
      send(10'h050, 10'h0D0, 16'd8, 8'h82, 1'b0, '0, acc);
      wait_idle("stall_idle");

`ifdef MAC_SEQ_BIAS_EN
      // bias beat leads three products
      rdy_mode = 0;
      beat_cyc.delete();
      send(10'h060, 10'h160, 16'd3, 8'hB1, 1'b1, 32'hFFFF_FF80, acc);
      wait_idle("bias_idle");
      chk("bias_nbeats", beat_cyc.size(), 4);
      if (beat_cyc.size() > 0) chk("bias_first_cycle", beat_cyc[0], acc + 2);
`endif

      // randomized commands and ready patterns
      for (int n = 0; n < 12; n++) begin
         rdy_mode = $urandom_range(0, 3);
         send(AW'($urandom), AW'($urandom), LW'($urandom_range(1, 12)), 8'($urandom),
`ifdef MAC_SEQ_BIAS_EN
              1'($urandom_range(0, 1)),
`else
              1'b0,
`endif
              $urandom, acc);
         wait_idle("rand_idle");
      end

      // reset while a long command is stalled mid-stream
      rdy_mode = 4;
      send(10'h200, 10'h300, 16'd16, 8'hC4, 1'b0, '0, acc);
      repeat (6) @(posedge ACLK);
      do_reset();
      @(negedge ACLK);
      chk("midrst_tvalid", M_AXIS_TVALID, 1'b0);
      chk("midrst_cmd_ready", CMD_READY, 1'b1);
      chk("midrst_busy", BUSY, 1'b0);
      rdy_mode = 0;
      send(10'h2A0, 10'h3A0, 16'd5, 8'hD5, 1'b0, '0, acc);
      wait_idle("post_rst_idle");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
